// File: rtl/ifetch_line_ctrl_pkg.sv
// ifetchPkg: shared types and constants for the single-line instruction
// fetch controller.
//   ifetch_state_t : controller FSM states (EMPTY, READY, REFILL)
//   NOP            : instruction returned whenever the line does not hit
package ifetchPkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    READY  = 2'd1,
    REFILL = 2'd2
  } ifetch_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h00000013;

endpackage

// File: rtl/ifetch_linebuf.sv
// ifetch_linebuf: lineWords x 32-bit storage for the fetch line.
//   clock : write clock
//   wen   : write enable, word waddr is loaded with wdata on the rising edge
//   waddr : word index to write
//   wdata : write data
//   raddr : word index to read
//   rdata : combinational read data (hits must be served in the same cycle)
module ifetch_linebuf #(
  parameter int lineWords = 4,
  localparam int AW = $clog2(lineWords)
) (
  input  logic          clock,
  input  logic          wen,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] words_reg [lineWords];

  // Contents carry no reset: validity is tracked by the controller.
  always_ff @(posedge clock) begin
    if (wen) begin
      words_reg[waddr] <= wdata;
    end
  end

  assign rdata = words_reg[raddr];

endmodule

// File: rtl/ifetch_line_ctrl.sv
// ifetch_line_ctrl: single-line instruction fetch controller.
// Serves fetches combinationally from one aligned line; on a miss it stalls
// the PC and refills the line word by word over a req/ack handshake.
//   clock, nReset : rising-edge clock, asynchronous active-low reset
//   ProgAddr      : fetch address from the PC (bits [1:0] ignored)
//   FlushLine     : invalidate the line (sampled on the clock edge)
//   Instruction   : fetched word on a hit, NOP otherwise
//   InsValid      : Instruction is valid for ProgAddr this cycle
//   InsCacheStall : PC stall, always !InsValid
//   MemReq/MemAddr: registered word read request and word-aligned address
//   MemAck/MemData: read acknowledge with same-cycle data
module ifetch_line_ctrl
  import ifetchPkg::*;
#(
  parameter int dataW     = 32,
  parameter int lineWords = 4
) (
  input  logic             clock,
  input  logic             nReset,
  input  logic [dataW-1:0] ProgAddr,
  input  logic             FlushLine,
  output logic [31:0]      Instruction,
  output logic             InsValid,
  output logic             InsCacheStall,
  output logic             MemReq,
  output logic [dataW-1:0] MemAddr,
  input  logic             MemAck,
  input  logic [31:0]      MemData
);

  localparam int OFFW = $clog2(lineWords);
  localparam int TAGW = dataW - OFFW - 2;
  localparam logic [OFFW-1:0] CNT_LAST = OFFW'(lineWords - 1);

  ifetch_state_t    state_reg,      state_next;
  logic             line_valid_reg, line_valid_next;
  logic [TAGW-1:0]  line_tag_reg,   line_tag_next;
  logic [OFFW-1:0]  cnt_reg,        cnt_next;
  logic [TAGW-1:0]  fill_tag_reg,   fill_tag_next;
  logic             flush_pend_reg, flush_pend_next;
  logic             mem_req_reg,    mem_req_next;
  logic [dataW-1:0] mem_addr_reg,   mem_addr_next;

  logic [OFFW-1:0]  offset;
  logic [TAGW-1:0]  tag;
  logic             hit;
  logic             buf_wen;
  logic [31:0]      buf_rdata;
  logic             unused_addr_bits;

  assign offset           = ProgAddr[OFFW+1:2];
  assign tag              = ProgAddr[dataW-1:OFFW+2];
  assign unused_addr_bits = ^ProgAddr[1:0];

  assign hit           = (state_reg == READY) && line_valid_reg && (tag == line_tag_reg);
  assign InsValid      = hit;
  assign InsCacheStall = !hit;
  assign Instruction   = hit ? buf_rdata : NOP;
  assign MemReq        = mem_req_reg;
  assign MemAddr       = mem_addr_reg;

  ifetch_linebuf #(.lineWords(lineWords)) u_linebuf (
    .clock (clock),
    .wen   (buf_wen),
    .waddr (cnt_reg),
    .wdata (MemData),
    .raddr (offset),
    .rdata (buf_rdata)
  );

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_reg      <= EMPTY;
      line_valid_reg <= 1'b0;
      line_tag_reg   <= '0;
      cnt_reg        <= '0;
      fill_tag_reg   <= '0;
      flush_pend_reg <= 1'b0;
      mem_req_reg    <= 1'b0;
      mem_addr_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      line_valid_reg <= line_valid_next;
      line_tag_reg   <= line_tag_next;
      cnt_reg        <= cnt_next;
      fill_tag_reg   <= fill_tag_next;
      flush_pend_reg <= flush_pend_next;
      mem_req_reg    <= mem_req_next;
      mem_addr_reg   <= mem_addr_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    line_valid_next = line_valid_reg;
    line_tag_next   = line_tag_reg;
    cnt_next        = cnt_reg;
    fill_tag_next   = fill_tag_reg;
    flush_pend_next = flush_pend_reg;
    mem_req_next    = mem_req_reg;
    mem_addr_next   = mem_addr_reg;
    buf_wen         = 1'b0;

    unique case (state_reg)
      EMPTY, READY: begin
        if (FlushLine) begin
          // Flush wins over a miss; the refill starts on the following edge.
          state_next      = EMPTY;
          line_valid_next = 1'b0;
        end else if (!hit) begin
          state_next      = REFILL;
          fill_tag_next   = tag;
          cnt_next        = '0;
          line_valid_next = 1'b0;
          mem_req_next    = 1'b1;
          mem_addr_next   = {tag, {OFFW{1'b0}}, 2'b00};
        end
      end
      REFILL: begin
        // The fill is never redirected; a flush only poisons its result.
        if (FlushLine) begin
          flush_pend_next = 1'b1;
        end
        if (MemAck) begin
          buf_wen  = 1'b1;
          cnt_next = cnt_reg + OFFW'(1);
          if (cnt_reg == CNT_LAST) begin
            state_next      = READY;
            line_tag_next   = fill_tag_reg;
            line_valid_next = !flush_pend_reg && !FlushLine;
            flush_pend_next = 1'b0;
            mem_req_next    = 1'b0;
          end else begin
            mem_addr_next = {fill_tag_reg, cnt_reg + OFFW'(1), 2'b00};
          end
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

endmodule
